// File: rtl/riscv_pkg.sv
// Shared pipeline types and constants used by the inter-stage registers.
package riscv_pkg;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned ILEN     = 32;
    localparam int unsigned FD_WIDTH = XLEN + ILEN + XLEN;

    localparam logic [ILEN-1:0] RISCV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        PR_EMPTY = 2'd0,
        PR_BUSY  = 2'd1,
        PR_FULL  = 2'd2
    } pr_state_e;

    // F/D boundary payload, most significant field first
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pcplus4;
    } fd_payload_t;

    // F/D bubble: zero PCs carrying a NOP so a squashed slot decodes harmlessly
    localparam logic [FD_WIDTH-1:0] FD_FLUSH_VAL = {{XLEN{1'b0}}, RISCV_NOP, {XLEN{1'b0}}};

endpackage

// File: rtl/riscv_pipe_skidreg.sv
// Two-entry elastic pipeline register (main + skid) with valid/ready on both sides.
// All outputs come straight from flops, so upstream and downstream never share a combinational path.
module riscv_pipe_skidreg
    import riscv_pkg::*;
#(
    parameter int unsigned       WIDTH     = 160,
    parameter logic [WIDTH-1:0]  FLUSH_VAL = '0
) (
    input  logic             i_riscv_pr_clk,
    input  logic             i_riscv_pr_rst_n,
    input  logic             i_riscv_pr_flush,
    input  logic             i_riscv_pr_valid_up,
    output logic             o_riscv_pr_ready_up,
    input  logic [WIDTH-1:0] i_riscv_pr_data_up,
    output logic             o_riscv_pr_valid_dn,
    input  logic             i_riscv_pr_ready_dn,
    output logic [WIDTH-1:0] o_riscv_pr_data_dn,
    output logic [1:0]       o_riscv_pr_occ
);

    pr_state_e        state_q;
    pr_state_e        state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_nxt;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_nxt;
    logic             ready_up_q;
    logic             valid_dn_q;
    logic [1:0]       occ_q;
    logic             in_fire;
    logic             out_fire;

    // Handshakes qualified by our own registered flags only
    assign in_fire  = i_riscv_pr_valid_up & ready_up_q;
    assign out_fire = valid_dn_q & i_riscv_pr_ready_dn;

    // Next state and entry updates; flush overrides any handshake
    always_comb begin
        state_nxt = state_q;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (i_riscv_pr_flush) begin
            state_nxt = PR_EMPTY;
            main_nxt  = FLUSH_VAL;
            skid_nxt  = FLUSH_VAL;
        end else begin
            case (state_q)
                PR_EMPTY: begin
                    if (in_fire) begin
                        state_nxt = PR_BUSY;
                        main_nxt  = i_riscv_pr_data_up;
                    end
                end
                PR_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_nxt = i_riscv_pr_data_up;
                    end else if (in_fire) begin
                        state_nxt = PR_FULL;
                        skid_nxt  = i_riscv_pr_data_up;
                    end else if (out_fire) begin
                        state_nxt = PR_EMPTY;
                        main_nxt  = FLUSH_VAL;
                    end
                end
                PR_FULL: begin
                    if (out_fire) begin
                        state_nxt = PR_BUSY;
                        main_nxt  = skid_q;
                        skid_nxt  = FLUSH_VAL;
                    end
                end
                default: begin
                    state_nxt = PR_EMPTY;
                    main_nxt  = FLUSH_VAL;
                    skid_nxt  = FLUSH_VAL;
                end
            endcase
        end
    end

    // State, entries and decoded status flags all registered together
    always_ff @(posedge i_riscv_pr_clk or negedge i_riscv_pr_rst_n) begin
        if (!i_riscv_pr_rst_n) begin
            state_q    <= PR_EMPTY;
            main_q     <= FLUSH_VAL;
            skid_q     <= FLUSH_VAL;
            ready_up_q <= 1'b1;
            valid_dn_q <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_nxt;
            main_q     <= main_nxt;
            skid_q     <= skid_nxt;
            ready_up_q <= (state_nxt != PR_FULL);
            valid_dn_q <= (state_nxt != PR_EMPTY);
            occ_q      <= {state_nxt == PR_FULL, state_nxt == PR_BUSY};
        end
    end

    assign o_riscv_pr_ready_up = ready_up_q;
    assign o_riscv_pr_valid_dn = valid_dn_q;
    assign o_riscv_pr_data_dn  = main_q;
    assign o_riscv_pr_occ      = occ_q;

endmodule

// File: tb/tb_riscv_pipe_skidreg.sv
// Self-checking bench for riscv_pipe_skidreg against a queue-based transfer model.
module tb_riscv_pipe_skidreg;
    import riscv_pkg::*;

    localparam int unsigned W = 160;
    localparam logic [W-1:0] FV = FD_FLUSH_VAL;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         valid_up;
    logic         ready_up;
    logic [W-1:0] data_up;
    logic         valid_dn;
    logic         ready_dn;
    logic [W-1:0] data_dn;
    logic [1:0]   occ;

    int total = 0;
    int bad   = 0;

    // Model: items currently held, oldest first, plus log of everything delivered
    logic [W-1:0] mq[$];
    logic [W-1:0] delivered[$];

    riscv_pipe_skidreg #(.WIDTH(W), .FLUSH_VAL(FV)) dut (
        .i_riscv_pr_clk      (clk),
        .i_riscv_pr_rst_n    (rst_n),
        .i_riscv_pr_flush    (flush),
        .i_riscv_pr_valid_up (valid_up),
        .o_riscv_pr_ready_up (ready_up),
        .i_riscv_pr_data_up  (data_up),
        .o_riscv_pr_valid_dn (valid_dn),
        .i_riscv_pr_ready_dn (ready_dn),
        .o_riscv_pr_data_dn  (data_dn),
        .o_riscv_pr_occ      (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: apply inputs before the edge, update the model, return at the next negedge
    task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        logic in_f;
        logic out_f;
        valid_up = v;
        data_up  = d;
        ready_dn = r;
        flush    = f;
        in_f  = v && (mq.size() < 2);
        out_f = r && (mq.size() > 0);
        @(posedge clk);
        if (out_f) delivered.push_back(mq.pop_front());
        if (f) mq.delete();
        else if (in_f) mq.push_back(d);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++; if (valid_dn !== 1'b0) begin bad++; $display("FAIL init_valid got=%b want=0", valid_dn); end
        total++; if (ready_up !== 1'b1) begin bad++; $display("FAIL init_ready got=%b want=1", ready_up); end
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        step(1'b1, 160'hA1, 1'b0, 1'b0);
        step(1'b1, 160'hA2, 1'b0, 1'b0);
        total++; if (occ !== 2'd2) begin bad++; $display("FAIL pre_reset_occ got=%0d want=2", occ); end
        // Assert reset mid-cycle while full and stalled
        #2 rst_n = 1'b0;
        #1;
        total++; if (valid_dn !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", valid_dn); end
        total++; if (ready_up !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", ready_up); end
        total++; if (occ !== 2'd0) begin bad++; $display("FAIL rst_occ got=%0d want=0", occ); end
        total++; if (data_dn !== FV) begin bad++; $display("FAIL rst_data got=%h want=%h", data_dn, FV); end
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        delivered.delete();
        step(1'b0, '0, 1'b1, 1'b0);
        total++; if (valid_dn !== 1'b0) begin bad++; $display("FAIL post_rst_valid got=%b want=0", valid_dn); end
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, W'(i), 1'b1, 1'b0);
            total++; if (data_dn !== W'(i)) begin bad++; $display("FAIL stream_data[%0d] got=%h want=%h", i, data_dn, W'(i)); end
            total++; if (valid_dn !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b want=1", i, valid_dn); end
            total++; if (occ !== 2'd1) begin bad++; $display("FAIL stream_occ[%0d] got=%0d want=1", i, occ); end
        end
        step(1'b0, '0, 1'b1, 1'b0);
        total++; if (valid_dn !== 1'b0) begin bad++; $display("FAIL stream_end_valid got=%b want=0", valid_dn); end
    endtask

    task automatic test_stall();
        logic [W-1:0] a, b, c;
        a = 160'hAAAA; b = 160'hBBBB; c = 160'hCCCC;
        delivered.delete();
        step(1'b1, a, 1'b0, 1'b0);
        total++; if (occ !== 2'd1) begin bad++; $display("FAIL stall_occ1 got=%0d want=1", occ); end
        step(1'b1, b, 1'b0, 1'b0);
        total++; if (occ !== 2'd2) begin bad++; $display("FAIL stall_occ2 got=%0d want=2", occ); end
        total++; if (ready_up !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b want=0", ready_up); end
        step(1'b1, c, 1'b0, 1'b0);
        total++; if (data_dn !== a) begin bad++; $display("FAIL stall_hold got=%h want=%h", data_dn, a); end
        total++; if (occ !== 2'd2) begin bad++; $display("FAIL stall_occ_hold got=%0d want=2", occ); end
        step(1'b1, c, 1'b1, 1'b0);
        total++; if (data_dn !== b) begin bad++; $display("FAIL release_b got=%h want=%h", data_dn, b); end
        step(1'b1, c, 1'b1, 1'b0);
        total++; if (data_dn !== c) begin bad++; $display("FAIL release_c got=%h want=%h", data_dn, c); end
        step(1'b0, '0, 1'b1, 1'b0);
        total++; if (valid_dn !== 1'b0) begin bad++; $display("FAIL release_empty got=%b want=0", valid_dn); end
        total++;
        if (delivered.size() != 3 || delivered[0] !== a || delivered[1] !== b || delivered[2] !== c) begin
            bad++; $display("FAIL stall_order got_count=%0d want=3", delivered.size());
        end
    endtask

    task automatic test_flush_full();
        logic [W-1:0] d;
        logic seen;
        d = 160'hDDDD;
        delivered.delete();
        step(1'b1, 160'h1111, 1'b0, 1'b0);
        step(1'b1, 160'h2222, 1'b0, 1'b0);
        step(1'b1, d, 1'b0, 1'b1);
        total++; if (occ !== 2'd0) begin bad++; $display("FAIL flush_occ got=%0d want=0", occ); end
        total++; if (valid_dn !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", valid_dn); end
        total++; if (data_dn !== FV) begin bad++; $display("FAIL flush_data got=%h want=%h", data_dn, FV); end
        total++; if (ready_up !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", ready_up); end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            if (valid_dn && data_dn === d) seen = 1'b1;
        end
        foreach (delivered[i]) if (delivered[i] === d) seen = 1'b1;
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%b want=0", seen); end
    endtask

    task automatic test_drain();
        logic [W-1:0] e;
        e = 160'hEEEE;
        step(1'b1, e, 1'b1, 1'b0);
        total++; if (valid_dn !== 1'b1 || data_dn !== e) begin bad++; $display("FAIL drain_e got=%b/%h want=1/%h", valid_dn, data_dn, e); end
        step(1'b0, '0, 1'b1, 1'b0);
        total++; if (valid_dn !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b want=0", valid_dn); end
        total++; if (data_dn !== FV) begin bad++; $display("FAIL drain_data got=%h want=%h", data_dn, FV); end
    endtask

    task automatic test_random();
        int sent;
        logic v, r;
        logic [W-1:0] d;
        logic [W-1:0] sent_log[$];
        logic order_ok;
        mq.delete();
        delivered.delete();
        sent = 0;
        d = rnd_word();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            if (v && mq.size() < 2) begin
                sent_log.push_back(d);
                sent++;
            end
            step(v, d, r, 1'b0);
            if (sent_log.size() > 0 && sent_log[$] === d) d = rnd_word();
            total++; if (valid_dn !== (mq.size() != 0)) begin bad++; $display("FAIL rnd_valid[%0d] got=%b want=%b", cyc, valid_dn, mq.size() != 0); end
            total++; if (occ !== 2'(mq.size())) begin bad++; $display("FAIL rnd_occ[%0d] got=%0d want=%0d", cyc, occ, mq.size()); end
            total++; if (ready_up !== (occ != 2'd2)) begin bad++; $display("FAIL rnd_ready[%0d] got=%b occ=%0d", cyc, ready_up, occ); end
            if (mq.size() != 0) begin
                total++; if (data_dn !== mq[0]) begin bad++; $display("FAIL rnd_data[%0d] got=%h want=%h", cyc, data_dn, mq[0]); end
            end else begin
                total++; if (data_dn !== FV) begin bad++; $display("FAIL rnd_bubble[%0d] got=%h want=%h", cyc, data_dn, FV); end
            end
        end
        order_ok = 1'b1;
        foreach (delivered[i]) if (delivered[i] !== sent_log[i]) order_ok = 1'b0;
        total++;
        if (!order_ok || delivered.size() + mq.size() != sent) begin
            bad++; $display("FAIL rnd_lossless got=%0d want=%0d", delivered.size() + mq.size(), sent);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        valid_up = 1'b0;
        ready_dn = 1'b0;
        data_up  = '0;
        @(negedge clk);
        test_reset();
        test_streaming();
        test_stall();
        test_flush_full();
        test_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
